rca_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 32-bit two-segment ripple-carry adder.
- Splits a WIDTH-bit add or subtract into NSEG = WIDTH/SEG_W ripple segments, with one pipeline register stage per segment.
- The inter-segment carry is registered, so the critical path is one SEG_W ripple and throughput is one operation per clock.
- Used as the accumulate/combine adder behind the complex multiplier's partial-product stages; a valid/ready handshake allows backpressure from downstream.

---
 rtl/rca_pipe_if.sv | 29 ++
 rtl/rca_pipe.sv | 106 ++++++++++
 tb/tb_rca_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_pipe_if.sv
// Operand/result handshake bundle for rca_pipe.
// Defining RCA_PIPE_OVF_EN adds the signed-overflow result bit ovf.
interface rca_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef RCA_PIPE_OVF_EN
   logic             ovf;

   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, s, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, s, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, s, cout);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, s, cout);
`endif
endinterface

// File: rtl/rca_pipe.sv
// Pipelined segmented ripple-carry add/subtract, one SEG_W segment per stage, global stall.
// Optional RCA_PIPE_OVF_EN: registered signed-overflow flag aligned with s.
module rca_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   rca_pipe_if.slave  bus
);
   localparam int NSEG = WIDTH / SEG_W;

   if (((WIDTH % SEG_W) != 0) || (NSEG < 1) || (NSEG > 16)) begin : g_cfg_check
      $error("rca_pipe: WIDTH must be a multiple of SEG_W giving 1..16 segments");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_beff;
   logic             w_ceff;
   logic [SEG_W:0]   w_sum [NSEG];

   logic             r_vld_p [NSEG];
   logic             r_cy_p  [NSEG];
   logic [WIDTH-1:0] r_sum_p [NSEG];
   logic [WIDTH-1:0] r_opa_p [NSEG];
   logic [WIDTH-1:0] r_opb_p [NSEG];

   // The whole pipe, bubbles included, moves only when the output slot frees up.
   assign w_adv  = ~r_vld_p[NSEG-1] | bus.out_ready;
   assign w_beff = bus.sub ? ~bus.b   : bus.b;
   assign w_ceff = bus.sub ? ~bus.cin : bus.cin;

   always_comb begin
      w_sum[0] = {1'b0, bus.a[SEG_W-1:0]} + {1'b0, w_beff[SEG_W-1:0]}
               + {{SEG_W{1'b0}}, w_ceff};
      for (int k = 1; k < NSEG; k++) begin
         w_sum[k] = {1'b0, r_opa_p[k-1][k*SEG_W +: SEG_W]}
                  + {1'b0, r_opb_p[k-1][k*SEG_W +: SEG_W]}
                  + {{SEG_W{1'b0}}, r_cy_p[k-1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            r_vld_p[k] <= 1'b0;
            r_cy_p[k]  <= 1'b0;
            r_sum_p[k] <= '0;
            r_opa_p[k] <= '0;
            r_opb_p[k] <= '0;
         end
      end else if (w_adv) begin
         // stage 0: conditioned operands enter, lowest segment added
         r_vld_p[0] <= bus.in_valid;
         r_cy_p[0]  <= w_sum[0][SEG_W];
         r_sum_p[0] <= WIDTH'(w_sum[0][SEG_W-1:0]);
         r_opa_p[0] <= bus.a;
         r_opb_p[0] <= w_beff;
         // stages 1..NSEG-1: add own segment with registered carry, skew the rest along
         for (int k = 1; k < NSEG; k++) begin
            r_vld_p[k] <= r_vld_p[k-1];
            r_cy_p[k]  <= w_sum[k][SEG_W];
            r_opa_p[k] <= r_opa_p[k-1];
            r_opb_p[k] <= r_opb_p[k-1];
            r_sum_p[k] <= r_sum_p[k-1];
            r_sum_p[k][k*SEG_W +: SEG_W] <= w_sum[k][SEG_W-1:0];
         end
      end
   end

`ifdef RCA_PIPE_OVF_EN
   logic w_a_msb;
   logic w_b_msb;
   logic w_cmsb;
   logic r_ovf;

   if (NSEG == 1) begin : g_msb_direct
      assign w_a_msb = bus.a[WIDTH-1];
      assign w_b_msb = w_beff[WIDTH-1];
   end else begin : g_msb_skew
      assign w_a_msb = r_opa_p[NSEG-2][WIDTH-1];
      assign w_b_msb = r_opb_p[NSEG-2][WIDTH-1];
   end

   // Carry into the MSB recovered from the MSB sum bit and its operand bits.
   assign w_cmsb = w_a_msb ^ w_b_msb ^ w_sum[NSEG-1][SEG_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_ovf <= w_cmsb ^ w_sum[NSEG-1][SEG_W];
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_vld_p[NSEG-1];
   assign bus.s         = r_sum_p[NSEG-1];
   assign bus.cout      = r_cy_p[NSEG-1];

   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.s) && $stable(bus.cout)));
endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe: directed steps plus random traffic against an arithmetic model.
module tb_rca_pipe;
`ifdef RCA_PIPE_OVF_EN
   localparam int W  = 16;
   localparam int SW = 16;
`else
   localparam int W  = 32;
   localparam int SW = 8;
`endif
   localparam int NSEG = W / SW;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rca_pipe_if #(.WIDTH(W)) bus ();
   rca_pipe #(.WIDTH(W), .SEG_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_pop = 0;
   int   last_pop_cyc = 0;
   exp_t q[$];
   exp_t e_mon;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operation as defined, not on segments.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb);
      logic [W:0] full;
      longint     sr;
      longint     lim;
      exp_t       e;
      lim = longint'(1) << (W - 1);
      if (!sb) begin
         full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
         sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      end else begin
         full = {1'b1, {W{1'b0}}} + {1'b0, a} - {1'b0, b} - (W+1)'(ci);
         sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
      end
      e.s = full[W-1:0];
      e.c = full[W];
      e.o = (sr >= lim) || (sr < -lim);
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 64'(q.size()), 64'd1);
            end else begin
               e_mon = q.pop_front();
               chk("s", 64'(bus.s), 64'(e_mon.s));
               chk("cout", 64'(bus.cout), 64'(e_mon.c));
`ifdef RCA_PIPE_OVF_EN
               chk("ovf", 64'(bus.ovf), 64'(e_mon.o));
`endif
               n_pop++;
               last_pop_cyc = cyc;
            end
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic one_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, output int lat, output logic [W-1:0] so,
                         output logic co, output logic oo);
      bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 4*NSEG + 8) begin
         step();
         lat++;
      end
      so = bus.s;
      co = bus.cout;
`ifdef RCA_PIPE_OVF_EN
      oo = bus.ovf;
`else
      oo = 1'b0;
`endif
   endtask

   task automatic drain(input string tag);
      int n = 0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      step();
      chk(tag, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat, sent, k, b0, c_start, n;
      logic [W-1:0] so, hold_s, ra, rb;
      logic         co, oo, hold_c, rc, rs;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_s", 64'(bus.s), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
`ifdef RCA_PIPE_OVF_EN
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      step();

      // Carry ripples through every segment
      one_op('1, W'(1), 1'b0, 1'b0, lat, so, co, oo);
      chk("carry_latency", 64'(lat), 64'(NSEG));
      chk("carry_s", 64'(so), 64'd0);
      chk("carry_cout", 64'(co), 64'd1);
      drain("drain_carry");

      one_op(W'(5), W'(7), 1'b0, 1'b1, lat, so, co, oo);
      chk("sub1_s", 64'(so), 64'({W{1'b1}} - W'(1)));
      chk("sub1_cout", 64'(co), 64'd0);
      one_op(W'(7), W'(5), 1'b1, 1'b1, lat, so, co, oo);
      chk("sub2_s", 64'(so), 64'd1);
      chk("sub2_cout", 64'(co), 64'd1);
      drain("drain_sub");

      // 100 back-to-back operations, no gaps expected
      b0 = n_pop;
      c_start = cyc;
      for (int i = 0; i < 100; i++) begin
         bus.a = W'(i); bus.b = W'(2*i); bus.cin = i[0]; bus.sub = 1'b0;
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      n = 0;
      while ((n_pop - b0) < 100 && n < 200) begin
         step();
         n++;
      end
      chk("burst_count", 64'(n_pop - b0), 64'd100);
      chk("burst_last_cycle", 64'(last_pop_cyc), 64'(c_start + 99 + NSEG));
      drain("drain_burst");

      // Backpressure: out_ready low for three cycles mid-stream
      b0 = n_pop;
      sent = 0;
      k = 0;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      while (sent < 10 && k < 100) begin
         bus.in_valid = 1'b1; bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs;
         bus.out_ready = !(k >= 6 && k < 9);
         #1;
         if (k == 6) begin
            hold_s = bus.s;
            hold_c = bus.cout;
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
         end
         if (k == 7 || k == 8) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_s_hold", 64'(bus.s), 64'(hold_s));
            chk("stall_cout_hold", 64'(bus.cout), 64'(hold_c));
         end
         if (bus.in_ready) begin
            sent++;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         end
         step();
         k++;
      end
      chk("bp_sent", 64'(sent), 64'd10);
      drain("drain_bp");
      chk("bp_count", 64'(n_pop - b0), 64'd10);

      // Asynchronous reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'b0; bus.sub = 1'b0;
         bus.in_valid = 1'b1; bus.out_ready = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_s", 64'(bus.s), 64'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("postrst_no_output", 64'(bus.out_valid), 64'd0);
      end
      one_op(W'(32'h1234_5678), W'(32'h0FED_CBA9), 1'b0, 1'b0, lat, so, co, oo);
      chk("postrst_latency", 64'(lat), 64'(NSEG));
      drain("drain_postrst");

      // Random traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.a = W'($urandom); bus.b = W'($urandom);
         bus.cin = 1'($urandom); bus.sub = 1'($urandom);
         step();
      end
      drain("drain_random");

`ifdef RCA_PIPE_OVF_EN
      one_op(W'(16'h7FFF), W'(16'h0001), 1'b0, 1'b0, lat, so, co, oo);
      chk("ovf1_s", 64'(so), 64'h8000);
      chk("ovf1_ovf", 64'(oo), 64'd1);
      one_op(W'(16'h8000), W'(16'h0001), 1'b0, 1'b1, lat, so, co, oo);
      chk("ovf2_s", 64'(so), 64'h7FFF);
      chk("ovf2_ovf", 64'(oo), 64'd1);
      one_op(W'(3), W'(4), 1'b0, 1'b0, lat, so, co, oo);
      chk("ovf3_s", 64'(so), 64'd7);
      chk("ovf3_ovf", 64'(oo), 64'd0);
      drain("drain_ovf");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
